// File: rtl/alu_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_uart_pkg
// Purpose  : Shared widths, ALU opcodes and controller state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package alu_uart_pkg;

    localparam int c_DBIT = 8;
    localparam int c_OP_W = 6;

    // Function codes understood by the ALU
    localparam logic [5:0] c_OP_ADD = 6'h20;
    localparam logic [5:0] c_OP_SUB = 6'h22;
    localparam logic [5:0] c_OP_AND = 6'h24;
    localparam logic [5:0] c_OP_OR  = 6'h25;

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SEND   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_uart_ctrl_frame_timer.sv
`default_nettype none
// ============================================================================
// Module   : frame_timer
// Purpose  : Inter-byte timeout counter; expired flags count == TIMEOUT-1.
// Revision : 1.0 - initial release
// ============================================================================
module frame_timer #(
    parameter int TIMEOUT = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int c_CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    // A zero TIMEOUT parameter disables expiry altogether
    assign expired = (TIMEOUT > 0) && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/alu_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_uart_ctrl
// Purpose  : Pops A/B/opcode from the RX flag buffer, runs the ALU, pushes result.
// Revision : 1.0 - initial release
// ============================================================================
module alu_uart_ctrl
    import alu_uart_pkg::*;
#(
    parameter int DBIT    = c_DBIT,
    parameter int OP_W    = c_OP_W,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] rx_data,
    output logic            rd_uart,
    input  logic            tx_full,
    output logic [DBIT-1:0] tx_data,
    output logic            wr_uart,
    output logic [DBIT-1:0] alu_a,
    output logic [DBIT-1:0] alu_b,
    output logic [OP_W-1:0] alu_op,
    input  logic [DBIT-1:0] alu_result,
    output logic            busy,
    output logic            frame_err
);

    state_t          r_state;
    state_t          w_next;
    logic            w_tmo_zone;
    logic            w_expired;
    logic [DBIT-1:0] r_a;
    logic [DBIT-1:0] r_b;
    logic [OP_W-1:0] r_op;
    logic [DBIT-1:0] r_res;

    assign w_tmo_zone = (r_state == GET_B) || (r_state == GET_OP);

    frame_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (rd_uart || frame_err),
        .en      (w_tmo_zone && rx_empty),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= GET_A;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        rd_uart   = 1'b0;
        wr_uart   = 1'b0;
        frame_err = 1'b0;
        case (r_state)
            GET_A: begin
                rd_uart = !rx_empty;
                if (!rx_empty) w_next = GET_B;
            end
            GET_B, GET_OP: begin
                rd_uart = !rx_empty;
                // An arriving byte wins over a simultaneous expiry
                if (!rx_empty) begin
                    w_next = (r_state == GET_B) ? GET_OP : EXEC;
                end else if (w_expired) begin
                    frame_err = 1'b1;
                    w_next    = GET_A;
                end
            end
            EXEC: begin
                w_next = SEND;
            end
            SEND: begin
                wr_uart = !tx_full;
                if (!tx_full) w_next = GET_A;
            end
            default: begin
                w_next = GET_A;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_res <= '0;
        end else begin
            if (rd_uart) begin
                case (r_state)
                    GET_A:   r_a  <= rx_data;
                    GET_B:   r_b  <= rx_data;
                    GET_OP:  r_op <= rx_data[OP_W-1:0];
                    default: ;
                endcase
            end
            if (r_state == EXEC) begin
                r_res <= alu_result;
            end
        end
    end

    assign alu_a   = r_a;
    assign alu_b   = r_b;
    assign alu_op  = r_op;
    assign tx_data = r_res;
    assign busy    = (r_state != GET_A);

endmodule
`default_nettype wire

// File: tb/tb_alu_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_uart_ctrl
// Purpose  : Directed self-checking bench for alu_uart_ctrl with a small ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_uart_ctrl;
    import alu_uart_pkg::*;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       rx_empty = 1'b1;
    logic [7:0] rx_data  = 8'h00;
    logic       tx_full  = 1'b0;
    logic       rd_uart;
    logic       wr_uart;
    logic       busy;
    logic       frame_err;
    logic [7:0] tx_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_result;

    int total = 0;
    int bad   = 0;
    int n_rd  = 0;
    int n_wr  = 0;
    int n_fe  = 0;
    logic [7:0] tx_log [0:31];

    alu_uart_ctrl #(
        .DBIT    (8),
        .OP_W    (6),
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_empty   (rx_empty),
        .rx_data    (rx_data),
        .rd_uart    (rd_uart),
        .tx_full    (tx_full),
        .tx_data    (tx_data),
        .wr_uart    (wr_uart),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = alu_a & alu_b;
        case (alu_op)
            c_OP_ADD: alu_result = alu_a + alu_b;
            c_OP_SUB: alu_result = alu_a - alu_b;
            default:  ;
        endcase
    end

    always @(posedge clk) begin
        if (rd_uart) n_rd <= n_rd + 1;
        if (wr_uart) begin
            tx_log[n_wr % 32] <= tx_data;
            n_wr <= n_wr + 1;
        end
        if (frame_err) n_fe <= n_fe + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input string tag);
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_empty = 1'b0;
        #1;
        chk({tag, "_rd"}, rd_uart, 1);
        @(negedge clk);
        rx_empty = 1'b1;
    endtask

    initial begin
        int s_rd;
        int s_wr;
        int s_fe;
        int idx;
        logic ok_wr;
        logic ok_tx;
        logic ok_busy;
        logic [7:0] bb [0:11];

        bb = '{8'h01, 8'h02, 8'h20, 8'h05, 8'h01, 8'h22,
               8'hFF, 8'h01, 8'h20, 8'h10, 8'h20, 8'h20};

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_wr", wr_uart, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_tx", tx_data, 0);
        chk("rst_a", alu_a, 0);
        reset = 1'b0;
        @(negedge clk);

        // Nominal frame with gaps
        s_rd = n_rd; s_wr = n_wr;
        send_byte(8'h05, 2, "nom_a");
        send_byte(8'h03, 3, "nom_b");
        send_byte(8'h20, 1, "nom_op");
        chk("nom_exec_busy", busy, 1);
        chk("nom_alu_a", alu_a, 8'h05);
        chk("nom_alu_b", alu_b, 8'h03);
        chk("nom_alu_op", alu_op, 6'h20);
        chk("nom_exec_wr", wr_uart, 0);
        @(negedge clk);
        chk("nom_send_wr", wr_uart, 1);
        chk("nom_send_tx", tx_data, 8'h08);
        @(negedge clk);
        chk("nom_idle_busy", busy, 0);
        chk("nom_pops", n_rd - s_rd, 3);
        chk("nom_pushes", n_wr - s_wr, 1);

        // TX backpressure
        s_wr = n_wr;
        tx_full = 1'b1;
        send_byte(8'h07, 0, "bp_a");
        send_byte(8'h02, 0, "bp_b");
        send_byte(8'h20, 0, "bp_op");
        @(negedge clk);
        ok_wr = 1'b1; ok_tx = 1'b1; ok_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (wr_uart !== 1'b0) ok_wr = 1'b0;
            if (tx_data !== 8'h09) ok_tx = 1'b0;
            if (busy !== 1'b1) ok_busy = 1'b0;
            @(negedge clk);
        end
        chk("bp_hold_wr", ok_wr, 1);
        chk("bp_tx_stable", ok_tx, 1);
        chk("bp_hold_busy", ok_busy, 1);
        tx_full = 1'b0;
        #1;
        chk("bp_release_wr", wr_uart, 1);
        chk("bp_release_tx", tx_data, 8'h09);
        @(negedge clk);
        chk("bp_idle_busy", busy, 0);
        chk("bp_pushes", n_wr - s_wr, 1);

        // Timeout after a lone byte
        s_fe = n_fe;
        send_byte(8'h11, 1, "tmo_a");
        ok_wr = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (frame_err !== 1'b0 || busy !== 1'b1) ok_wr = 1'b0;
            @(negedge clk);
        end
        chk("tmo_quiet", ok_wr, 1);
        chk("tmo_ferr", frame_err, 1);
        chk("tmo_busy_at_exp", busy, 1);
        @(negedge clk);
        chk("tmo_back_idle", busy, 0);
        chk("tmo_ferr_pulse", frame_err, 0);
        chk("tmo_partial_kept", alu_a, 8'h11);
        chk("tmo_ferr_count", n_fe - s_fe, 1);
        send_byte(8'h02, 1, "tmo2_a");
        send_byte(8'h02, 1, "tmo2_b");
        send_byte(8'h22, 1, "tmo2_op");
        @(negedge clk);
        chk("tmo2_wr", wr_uart, 1);
        chk("tmo2_tx", tx_data, 8'h00);
        @(negedge clk);

        // Byte arriving in the expiry cycle
        s_fe = n_fe;
        send_byte(8'h09, 0, "exp_a");
        repeat (15) @(negedge clk);
        rx_data  = 8'h04;
        rx_empty = 1'b0;
        #1;
        chk("exp_rd", rd_uart, 1);
        chk("exp_no_ferr", frame_err, 0);
        @(negedge clk);
        rx_empty = 1'b1;
        chk("exp_in_getop", busy, 1);
        send_byte(8'h20, 0, "exp_op");
        @(negedge clk);
        chk("exp_wr", wr_uart, 1);
        chk("exp_tx", tx_data, 8'h0D);
        @(negedge clk);
        chk("exp_ferr_count", n_fe - s_fe, 0);

        // Asynchronous reset in GET_OP
        send_byte(8'h30, 0, "mid_a");
        send_byte(8'h40, 0, "mid_b");
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_a_clr", alu_a, 0);
        chk("mid_b_clr", alu_b, 0);
        chk("mid_op_clr", alu_op, 0);
        chk("mid_tx_clr", tx_data, 0);
        @(negedge clk);
        reset = 1'b0;
        send_byte(8'h0A, 1, "mid2_a");
        send_byte(8'h01, 0, "mid2_b");
        send_byte(8'h22, 0, "mid2_op");
        chk("mid2_alu_a", alu_a, 8'h0A);
        @(negedge clk);
        chk("mid2_wr", wr_uart, 1);
        chk("mid2_tx", tx_data, 8'h09);
        @(negedge clk);

        // Back-to-back frames with rx_empty held low
        s_rd = n_rd; s_wr = n_wr;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            if (idx < 12) begin
                rx_data  = bb[idx];
                rx_empty = 1'b0;
            end else begin
                rx_empty = 1'b1;
            end
            #1;
            if (rd_uart) idx++;
            @(negedge clk);
        end
        rx_empty = 1'b1;
        chk("b2b_pops", n_rd - s_rd, 12);
        chk("b2b_pushes", n_wr - s_wr, 4);
        chk("b2b_tx0", tx_log[(s_wr + 0) % 32], 8'h03);
        chk("b2b_tx1", tx_log[(s_wr + 1) % 32], 8'h04);
        chk("b2b_tx2", tx_log[(s_wr + 2) % 32], 8'h00);
        chk("b2b_tx3", tx_log[(s_wr + 3) % 32], 8'h30);
        chk("b2b_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
